// File: rtl/systolic_mm_engine_if.sv
// systolic_mm_engine_if: weight-load, X-row and Y-row handshake bundle for systolic_mm_engine
interface systolic_mm_engine_if #(
   parameter int N = 3,
   parameter int K = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH = 20
);
   logic                          w_load;
   logic [N*K*DATA_WIDTH-1:0]     w_data;
   logic                          x_valid;
   logic                          x_ready;
   logic [N*DATA_WIDTH-1:0]       x_data;
   logic                          x_last;
   logic                          y_valid;
   logic                          y_ready;
   logic [K*ACC_WIDTH-1:0]        y_data;
   modport master (output w_load, w_data, x_valid, x_data, x_last, y_ready,
                   input  x_ready, y_valid, y_data);
   modport slave  (input  w_load, w_data, x_valid, x_data, x_last, y_ready,
                   output x_ready, y_valid, y_data);
endinterface

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: weight-stationary systolic Y = X*W engine with skew/de-skew, backpressure and batch drain; SYSTOLIC_RELU_EN adds output ReLU
module systolic_mm_engine #(
   parameter int N = 3,
   parameter int K = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   systolic_mm_engine_if.slave bus,
   output logic                busy,
   output logic                done
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = ACC_WIDTH;
   localparam int L = N + K;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;
   logic adv, x_fire, y_fire, last_out, w_loaded_q, done_q;
   logic [L-1:0] v_q, l_q;
   logic [K*AW-1:0] y_q, y_d;
   logic signed [DW-1:0] w_q [N][K];
   logic signed [DW-1:0] x_q [N][K];
   logic signed [AW-1:0] p_q [N][K];
   logic signed [DW-1:0] x_in [N];
   logic signed [AW-1:0] col [K];

   assign adv         = !(bus.y_valid && !bus.y_ready);
   assign bus.x_ready = w_loaded_q && adv && (state_q != DRAIN);
   assign x_fire      = bus.x_valid && bus.x_ready;
   assign y_fire      = bus.y_valid && bus.y_ready;
   assign last_out    = y_fire && l_q[L-1];
   assign bus.y_valid = v_q[L-1];
   assign bus.y_data  = y_q;
   assign busy        = state_q != IDLE;
   assign done        = done_q;

   for (genvar n = 0; n < N; n++) begin : g_skew
      logic signed [DW-1:0] xr;
      assign xr = x_fire ? bus.x_data[n*DW +: DW] : '0;
      if (n == 0) begin : g_nd
         assign x_in[n] = xr;
      end else begin : g_d
         logic signed [DW-1:0] s_q [n];
         // delay row n by n stages so its element meets the right partial sum
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) s_q <= '{default: '0};
            else if (adv) begin
               s_q[0] <= xr;
               for (int j = 1; j < n; j++) s_q[j] <= s_q[j-1];
            end
         assign x_in[n] = s_q[n-1];
      end
   end

   for (genvar n = 0; n < N; n++) begin : g_pe_r
      for (genvar k = 0; k < K; k++) begin : g_pe_c
         logic signed [DW-1:0] a;
         logic signed [AW-1:0] b, m;
         logic signed [2*DW-1:0] prod;
         if (k == 0) assign a = x_in[n];
         else        assign a = x_q[n][k-1];
         if (n == 0) assign b = '0;
         else        assign b = p_q[n-1][k];
         assign prod = a * w_q[n][k];
         assign m    = AW'(prod);
         // PE: pass x right, accumulate partial sum downward
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               x_q[n][k] <= '0;
               p_q[n][k] <= '0;
            end else if (adv) begin
               x_q[n][k] <= a;
               p_q[n][k] <= b + m;
            end
      end
   end

   for (genvar k = 0; k < K; k++) begin : g_dsk
      localparam int D = K - 1 - k;
      if (D == 0) begin : g_nd
         assign col[k] = p_q[N-1][k];
      end else begin : g_d
         logic signed [AW-1:0] d_q [D];
         // delay column k so all columns of a row land together
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) d_q <= '{default: '0};
            else if (adv) begin
               d_q[0] <= p_q[N-1][k];
               for (int j = 1; j < D; j++) d_q[j] <= d_q[j-1];
            end
         assign col[k] = d_q[D-1];
      end
   end

   // output row ahead of the output register, optionally rectified
   always_comb begin
      y_d = '0;
      for (int i = 0; i < K; i++)
`ifdef SYSTOLIC_RELU_EN
         y_d[i*AW +: AW] = col[i][AW-1] ? '0 : col[i];
`else
         y_d[i*AW +: AW] = col[i];
`endif
   end

   // batch FSM: run until the last row is accepted, drain until it is taken
   always_comb begin
      state_d = state_q;
      if (state_q != DRAIN && x_fire) state_d = bus.x_last ? DRAIN : RUN;
      else if (state_q == DRAIN && last_out) state_d = IDLE;
   end

   // state, weights, valid/last tracking and the held output row
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         w_loaded_q <= 1'b0;
         done_q     <= 1'b0;
         v_q        <= '0;
         l_q        <= '0;
         y_q        <= '0;
         w_q        <= '{default: '0};
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DRAIN) && last_out;
         if (state_q == IDLE && bus.w_load) begin
            w_loaded_q <= 1'b1;
            for (int n = 0; n < N; n++)
               for (int k = 0; k < K; k++) w_q[n][k] <= bus.w_data[(n*K+k)*DW +: DW];
         end
         if (adv) begin
            v_q <= {v_q[L-2:0], x_fire};
            l_q <= {l_q[L-2:0], x_fire && bus.x_last};
            if (v_q[L-2]) y_q <= y_d;
         end
      end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed vector table plus stall, burst, weight-lock and reset sequences
module tb_systolic_mm_engine;
   localparam int N = 3;
   localparam int K = 4;
   localparam int DW = 8;
   localparam int AW = 20;
   localparam int L = N + K;
`ifdef SYSTOLIC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif
   typedef struct {
      logic [N*K*DW-1:0] w;
      logic [N*DW-1:0]   x;
      logic [K*AW-1:0]   y;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, done;
   int passed = 0;
   int total = 0;
   vec_t tbl [5];
   logic [N*K*DW-1:0] ones, ident;

   systolic_mm_engine_if #(.N(N), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
   systolic_mm_engine #(.N(N), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, a, e);
   endtask

   function automatic logic [N*DW-1:0] px(input int a0, input int a1, input int a2);
      int v [3];
      logic [N*DW-1:0] r;
      v = '{a0, a1, a2};
      for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i][DW-1:0];
      return r;
   endfunction

   function automatic logic [K*AW-1:0] py(input int a0, input int a1, input int a2, input int a3);
      int v [4];
      logic [K*AW-1:0] r;
      v = '{a0, a1, a2, a3};
      for (int i = 0; i < K; i++) r[i*AW +: AW] = v[i][AW-1:0];
      return r;
   endfunction

   function automatic logic [N*K*DW-1:0] pw(input int a [12]);
      logic [N*K*DW-1:0] r;
      for (int i = 0; i < N*K; i++) r[i*DW +: DW] = a[i][DW-1:0];
      return r;
   endfunction

   task automatic load_w(input logic [N*K*DW-1:0] w);
      @(negedge clk);
      bus.w_load = 1'b1;
      bus.w_data = w;
      @(negedge clk);
      bus.w_load = 1'b0;
   endtask

   task automatic send(input logic [N*DW-1:0] x, input logic last);
      int t;
      t = 0;
      bus.x_valid = 1'b1;
      bus.x_data = x;
      bus.x_last = last;
      while (!bus.x_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!bus.x_ready) chk("x_accept_timeout", bus.x_ready, 1);
      @(negedge clk);
      bus.x_valid = 1'b0;
   endtask

   // lat counts the cycle this is called in as 1
   task automatic get_y(input logic [K*AW-1:0] e, input string nm, output int lat);
      bus.y_ready = 1'b1;
      lat = 1;
      while (!bus.y_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_valid"}, bus.y_valid, 1);
      chk(nm, bus.y_data, e);
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int i);
      int lat;
      load_w(v.w);
      send(v.x, 1'b1);
      chk($sformatf("busy_vec%0d", i), busy, 1);
      get_y(v.y, $sformatf("y_vec%0d", i), lat);
      chk($sformatf("lat_vec%0d", i), lat, L);
      chk($sformatf("done_vec%0d", i), done, 1);
      chk($sformatf("yv_low_vec%0d", i), bus.y_valid, 0);
      @(negedge clk);
      chk($sformatf("done_drop_vec%0d", i), done, 0);
      chk($sformatf("idle_vec%0d", i), busy, 0);
   endtask

   initial begin
      int lat, t, bad;
      ones  = pw('{1,1,1,1, 1,1,1,1, 1,1,1,1});
      ident = pw('{1,0,0,0, 0,1,0,0, 0,0,1,0});
      tbl[0] = '{ones, px(1,2,1), py(4,4,4,4)};
      tbl[1] = '{ident, px(1,2,3), py(1,2,3,0)};
      tbl[2] = '{pw('{-1,-1,-1,-1, -1,-1,-1,-1, -1,-1,-1,-1}), px(127,127,127),
                 RELU ? py(0,0,0,0) : py(-381,-381,-381,-381)};
      tbl[3] = '{pw('{1,2,3,4, -1,0,1,2, 2,-2,0,1}), px(3,-2,5),
                 RELU ? py(15,0,7,13) : py(15,-4,7,13)};
      tbl[4] = '{pw('{-128,-128,-128,-128, -128,-128,-128,-128, -128,-128,-128,-128}),
                 px(-128,-128,-128), py(49152,49152,49152,49152)};
      bus.w_load = 1'b0;
      bus.w_data = '0;
      bus.x_valid = 1'b0;
      bus.x_data = '0;
      bus.x_last = 1'b0;
      bus.y_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_x_ready", bus.x_ready, 0);
      chk("rst_y_valid", bus.y_valid, 0);
      chk("rst_y_data", bus.y_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.x_valid = 1'b1;
      bus.x_data = px(1,1,1);
      chk("ready_before_load", bus.x_ready, 0);
      @(negedge clk);
      chk("busy_before_load", busy, 0);
      bus.x_valid = 1'b0;
      for (int i = 0; i < 5; i++) run_vec(tbl[i], i);
      // back-to-back burst through identity weights
      load_w(ident);
      send(px(1,2,3), 1'b0);
      send(px(4,5,6), 1'b0);
      send(px(7,8,9), 1'b1);
      get_y(py(1,2,3,0), "burst0", lat);
      chk("burst0_lat", lat, L-2);
      get_y(py(4,5,6,0), "burst1", lat);
      chk("burst1_lat", lat, 1);
      get_y(py(7,8,9,0), "burst2", lat);
      chk("burst2_lat", lat, 1);
      chk("burst_done", done, 1);
      @(negedge clk);
      chk("burst_idle", busy, 0);
      // output backpressure with three rows in flight and a fourth waiting
      bus.y_ready = 1'b0;
      send(px(1,2,3), 1'b0);
      send(px(4,5,6), 1'b0);
      send(px(7,8,9), 1'b0);
      t = 0;
      while (!bus.y_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      bus.x_valid = 1'b1;
      bus.x_data = px(2,0,5);
      bus.x_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_x_ready", bus.x_ready, 0);
         chk("stall_y_valid", bus.y_valid, 1);
         chk("stall_y_data", bus.y_data, py(1,2,3,0));
         @(negedge clk);
      end
      get_y(py(1,2,3,0), "bp0", lat);
      bus.x_valid = 1'b0;
      get_y(py(4,5,6,0), "bp1", lat);
      chk("bp1_lat", lat, 1);
      get_y(py(7,8,9,0), "bp2", lat);
      chk("bp2_lat", lat, 1);
      get_y(py(2,0,5,0), "bp3", lat);
      chk("bp3_lat", lat, L-2);
      chk("bp_done", done, 1);
      // weight load while running is ignored
      load_w(ones);
      send(px(1,2,1), 1'b0);
      bus.w_load = 1'b1;
      bus.w_data = ident;
      chk("wrun_busy", busy, 1);
      @(negedge clk);
      bus.w_load = 1'b0;
      send(px(1,2,3), 1'b1);
      get_y(py(4,4,4,4), "wrun0", lat);
      get_y(py(6,6,6,6), "wrun1", lat);
      chk("wrun_done", done, 1);
      load_w(ident);
      send(px(1,2,3), 1'b1);
      get_y(py(1,2,3,0), "widle", lat);
      chk("widle_done", done, 1);
      // reset in the middle of a stalled batch
      bus.y_ready = 1'b0;
      send(px(1,2,3), 1'b0);
      t = 0;
      while (!bus.y_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("pre_rst_y_valid", bus.y_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_y_valid", bus.y_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_x_ready", bus.x_ready, 0);
      chk("mid_rst_y_data", bus.y_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.x_valid = 1'b1;
      bus.x_data = px(1,1,1);
      bus.x_last = 1'b1;
      bus.y_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || bus.y_valid || bus.x_ready) bad++;
         @(negedge clk);
      end
      chk("post_rst_quiet", bad, 0);
      bus.x_valid = 1'b0;
      load_w(ident);
      chk("ready_after_load", bus.x_ready, 1);
      send(px(4,5,6), 1'b1);
      get_y(py(4,5,6,0), "recover", lat);
      chk("recover_lat", lat, L);
      chk("recover_done", done, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised, self-contained weight-stationary systolic matrix-multiply engine computing Y = X·W, where W is an N×K weight tile and X is streamed row by row.
- Generalises the fixed 3×4, 8-bit array by adding:
  - signed accumulation at a configurable width,
  - internal input skew and output de-skew,
  - valid/ready handshakes with output backpressure,
  - a weight-load path,
  - a drain/done sequence.
- Sits between the row-fetch logic and the result writeback in the accelerator datapath.

Parameters:
- N, 3, rows of PE grid = elements per X row (reduction length).
- K, 4, columns of PE grid = elements per Y row.
- DATA_WIDTH, 8, signed width of X and W elements.
- ACC_WIDTH, 20, signed width of Y elements and partial sums; must be ≥ 2*DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- w_load  in  1  pulse to capture w_data into all PEs.
- w_data  in  N*K*DATA_WIDTH  element (n,k) at bits [(n*K+k)*DATA_WIDTH +: DATA_WIDTH].
- x_valid  in  1  X row offered.
- x_ready  out  1  engine accepts X row this cycle.
- x_data  in  N*DATA_WIDTH  element n at bits [n*DATA_WIDTH +: DATA_WIDTH].
- x_last  in  1  marks final row of a batch; sampled with the x handshake.
- y_valid  out  1  Y row available.
- y_ready  in  1  consumer accepts Y row.
- y_data  out  K*ACC_WIDTH  element k at bits [k*ACC_WIDTH +: ACC_WIDTH].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last Y row of a batch is taken.

Behaviour:
- Reset (async, rst_n=0): all PE weights, skew and pipeline registers cleared to 0; w_loaded=0, state=IDLE, x_ready=0, y_valid=0, y_data=0, busy=0, done=0.
- Arithmetic: signed two's complement. PE(n,k) computes psum_out = psum_in + x·w with the product sign-extended to ACC_WIDTH; overflow wraps modulo 2^ACC_WIDTH. Top-row psum_in is 0.
- Dataflow: x element n enters row n after n stages of skew and travels right along k; partial sums travel down along n. Column k output is de-skewed by K-1-k stages so that all K elements of a Y row appear together.
- advance = !(y_valid && !y_ready). All skew, PE and de-skew registers update only when advance=1; a stall freezes everything, including y_data.
- Latency: exactly N+K advancing cycles from x handshake to y_valid for that row. Rows come out in order. Throughput is 1 row/cycle without backpressure.
- x_ready = w_loaded && advance && (state != DRAIN). When no row is accepted in an advancing cycle, a bubble is inserted and produces no y_valid.
- Weight load: w_load is honoured only when state=IDLE. It captures w_data in that cycle and sets w_loaded=1. w_load in RUN or DRAIN is ignored and leaves weights unchanged.
- FSM:
  - IDLE -> RUN on an x handshake with x_last=0.
  - IDLE -> DRAIN on an x handshake with x_last=1.
  - RUN -> DRAIN on an x handshake with x_last=1.
  - DRAIN -> IDLE when the y handshake of the last row occurs; done=1 in the following cycle only.
  - A single-row batch is legal.
- A y handshake with a simultaneous x handshake is legal; both complete in the same cycle.
- y_data is undefined-free: it holds its last value when y_valid=0.
- Reset mid-batch discards all in-flight rows, clears weights, and produces no done.

Optional Feature:
- Macro SYSTOLIC_RELU_EN.
  - Defined: each y_data element is passed through ReLU after de-skew; negative values output as 0. Latency is unchanged (combinational on the output register input).
  - Undefined: raw signed accumulations are output.

Test Plan:
- Load all w=1; stream x=(1,2,1) with x_last=1 -> after N+K=7 cycles y_valid=1, all four y elements = 4; done pulses 1 cycle after the y handshake; busy returns to 0.
- Load w(n,k)=1 if n==k else 0; stream rows (1,2,3),(4,5,6),(7,8,9) back-to-back -> outputs (1,2,3,0),(4,5,6,0),(7,8,9,0) in consecutive cycles, in order.
- Load all w=-1 (0xFF); x=(127,127,127) -> y = -381 per element without SYSTOLIC_RELU_EN, 0 with it.
- Hold y_ready=0 for 5 cycles while 3 rows are in flight -> x_ready=0, y_data stable; on release the same 3 correct rows emerge with no loss or duplication.
- Assert w_load with new weights in RUN -> ignored; results use the old weights. Assert w_load in IDLE -> new weights used.
- Deassert rst_n mid-batch -> y_valid, busy and x_ready go to 0 immediately; no done; x_ready stays 0 until a new w_load.
